// File: rtl/keypad_pkg.sv
// Shared constants, FSM state type and key-map helper for the keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } key_state_t;

  // Map a (row, column) position to the one-hot code of its hex digit.
  // Rows: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = E 0 F D.
  function automatic logic [15:0] key_onehot(input logic [1:0] row_idx,
                                             input logic [1:0] col_idx);
    logic [3:0] digit;
    digit = 4'h0;
    case ({row_idx, col_idx})
      4'h0: digit = 4'h1;
      4'h1: digit = 4'h2;
      4'h2: digit = 4'h3;
      4'h3: digit = 4'hA;
      4'h4: digit = 4'h4;
      4'h5: digit = 4'h5;
      4'h6: digit = 4'h6;
      4'h7: digit = 4'hB;
      4'h8: digit = 4'h7;
      4'h9: digit = 4'h8;
      4'hA: digit = 4'h9;
      4'hB: digit = 4'hC;
      4'hC: digit = 4'hE;
      4'hD: digit = 4'h0;
      4'hE: digit = 4'hF;
      4'hF: digit = 4'hD;
      default: digit = 4'h0;
    endcase
    return 16'h0001 << digit;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad-side and key-event signals of the scanner, bundled for port use.
interface keypad_scan_if;
  import keypad_pkg::*;

  logic [NUM_ROWS-1:0] row;
  logic [NUM_COLS-1:0] col;
  logic                new_key;
  logic [15:0]         key_pressed_value;

  // master: the scanner itself; slave: the keypad / downstream consumer side.
  modport master (input row, output col, output new_key, output key_pressed_value);
  modport slave  (output row, input col, input new_key, input key_pressed_value);
endinterface

// File: rtl/keypad_scan_ticker.sv
// Free-running divider producing a one-clk scan tick every SCAN_DIV clocks.
module scan_ticker #(
  parameter int SCAN_DIV = 4000
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Wrap to zero after the last count, otherwise count up.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // Divider state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column drive, row synchronizer, press/release debounce,
// and a single new_key strobe with a one-hot code per accepted press.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 4000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic          clk,
  input  logic          reset,
  keypad_scan_if.master kp
);

  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic tick;

  scan_ticker #(.SCAN_DIV(SCAN_DIV)) u_ticker (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

  logic [NUM_ROWS-1:0] sync1_q;
  logic [NUM_ROWS-1:0] rs_q;

  // Two-flop synchronizer for the asynchronous row inputs; idle rows read high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '1;
      rs_q    <= '1;
    end else begin
      sync1_q <= kp.row;
      rs_q    <= sync1_q;
    end
  end

  key_state_t          state_q;
  logic [NUM_COLS-1:0] col_q;
  logic [1:0]          row_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                new_key_q;
  logic [15:0]         value_q;

  logic [1:0]          low_row;
  logic                any_low;
  logic [1:0]          col_idx;
  logic                cand_low;
  logic [CNT_W-1:0]    cnt_inc;
  logic [NUM_COLS-1:0] col_rot;

  // Lowest-index low row wins when several rows are pressed.
  always_comb begin
    low_row = 2'd0;
    any_low = 1'b0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rs_q[i]) begin
        low_row = 2'(i);
        any_low = 1'b1;
      end
    end
  end

  // Index of the single active-low column, plus its rotated successor.
  always_comb begin
    col_idx = 2'd0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (!col_q[i]) col_idx = 2'(i);
    end
    col_rot  = {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
    cand_low = ~rs_q[row_q];
    cnt_inc  = cnt_q + 1'b1;
  end

  // Scan / debounce FSM; every decision is taken on a scan tick only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SCAN;
      col_q     <= 4'b1110;
      row_q     <= 2'd0;
      cnt_q     <= '0;
      new_key_q <= 1'b0;
      value_q   <= 16'h0000;
    end else begin
      new_key_q <= 1'b0;
      if (tick) begin
        case (state_q)
          SCAN: begin
            if (!any_low) begin
              col_q <= col_rot;
            end else begin
              row_q <= low_row;
              cnt_q <= CNT_ONE;
              if (DEBOUNCE_CNT == 1) begin
                value_q   <= key_onehot(low_row, col_idx);
                new_key_q <= 1'b1;
                state_q   <= HELD;
              end else begin
                state_q <= PRESS_DB;
              end
            end
          end
          PRESS_DB: begin
            if (cand_low) begin
              cnt_q <= cnt_inc;
              if (cnt_inc == DB_MAX) begin
                value_q   <= key_onehot(row_q, col_idx);
                new_key_q <= 1'b1;
                state_q   <= HELD;
              end
            end else begin
              state_q <= SCAN;
            end
          end
          HELD: begin
            if (!cand_low) begin
              cnt_q <= CNT_ONE;
              if (DEBOUNCE_CNT == 1) begin
                col_q   <= col_rot;
                state_q <= SCAN;
              end else begin
                state_q <= RELEASE_DB;
              end
            end
          end
          RELEASE_DB: begin
            if (!cand_low) begin
              cnt_q <= cnt_inc;
              if (cnt_inc == DB_MAX) begin
                col_q   <= col_rot;
                state_q <= SCAN;
              end
            end else begin
              state_q <= HELD;
            end
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

  assign kp.col               = col_q;
  assign kp.new_key           = new_key_q;
  assign kp.key_pressed_value = value_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: keypad matrix model, tick-level reference model,
// directed segment table, reset-in-flight sequence and random key activity.
module tb_keypad_scan;

  localparam int SD = 4;
  localparam int DB = 3;

  localparam int M_SCAN = 0;
  localparam int M_PRESS = 1;
  localparam int M_HELD = 2;
  localparam int M_REL = 3;

  logic clk;
  logic reset;
  logic [15:0] keys;
  logic [3:0] row_drv;

  keypad_scan_if kif ();

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif)
  );

  int digit_of [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

  int tests = 0;
  int fails = 0;
  int obs_pulses = 0;

  // reference model state
  int m_mode = M_SCAN;
  int m_col = 0;
  int m_row = 0;
  int m_cnt = 0;
  logic [15:0] m_value = 16'h0000;
  int m_pulses = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Passive keypad: a row is pulled low when a pressed key sits on the driven column.
  always_comb begin
    row_drv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kif.col[c] && keys[digit_of[r][c]]) row_drv[r] = 1'b0;
  end
  assign kif.row = row_drv;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_SCAN;
    m_col   = 0;
    m_row   = 0;
    m_cnt   = 0;
    m_value = 16'h0000;
  endtask

  task automatic model_accept(output bit pulse);
    m_value = 16'(32'h1 << digit_of[m_row][m_col]);
    m_pulses++;
    pulse  = 1'b1;
    m_mode = M_HELD;
  endtask

  // One scan tick of the behaviour, given the keys held during that tick interval.
  task automatic model_tick(input logic [15:0] k, output bit pulse);
    int  low;
    bit  cand;
    low   = -1;
    pulse = 1'b0;
    for (int r = 3; r >= 0; r--) if (k[digit_of[r][m_col]]) low = r;
    cand = k[digit_of[m_row][m_col]];
    case (m_mode)
      M_SCAN: begin
        if (low < 0) m_col = (m_col + 1) % 4;
        else begin
          m_row = low;
          m_cnt = 1;
          if (m_cnt >= DB) model_accept(pulse);
          else m_mode = M_PRESS;
        end
      end
      M_PRESS: begin
        if (cand) begin
          m_cnt++;
          if (m_cnt == DB) model_accept(pulse);
        end else m_mode = M_SCAN;
      end
      M_HELD: begin
        if (!cand) begin
          m_cnt = 1;
          if (m_cnt >= DB) begin m_mode = M_SCAN; m_col = (m_col + 1) % 4; end
          else m_mode = M_REL;
        end
      end
      default: begin
        if (!cand) begin
          m_cnt++;
          if (m_cnt == DB) begin m_mode = M_SCAN; m_col = (m_col + 1) % 4; end
        end else m_mode = M_HELD;
      end
    endcase
  endtask

  // Hold keys for one tick interval; called right after a tick edge (counter at 0).
  task automatic tick_step(input logic [15:0] k);
    bit p;
    logic [3:0] ecol;
    keys = k;
    model_tick(k, p);
    for (int e = 1; e <= SD; e++) begin
      @(posedge clk);
      #1;
      if (kif.new_key) obs_pulses++;
      if (e < SD) check("new_key_idle", 32'(kif.new_key), 32'(0));
      else        check("new_key_tick", 32'(kif.new_key), 32'(p));
    end
    ecol = ~(4'b0001 << m_col);
    check("col", 32'(kif.col), 32'(ecol));
    check("value", 32'(kif.key_pressed_value), 32'(m_value));
  endtask

  typedef struct {
    logic [15:0] keys;
    int          ticks;
    logic [3:0]  exp_col;
    logic [15:0] exp_val;
    int          exp_pulses;
  } seg_t;

  seg_t segs [17];

  initial begin
    logic [15:0] rk;
    int kind;
    int dur;

    segs[0]  = '{16'h0000, 5,  4'b1101, 16'h0000, 0};  // idle scan
    segs[1]  = '{16'h0020, 10, 4'b1101, 16'h0020, 1};  // key 5 held
    segs[2]  = '{16'h0000, 3,  4'b1011, 16'h0020, 1};  // released, resume
    segs[3]  = '{16'h0000, 1,  4'b0111, 16'h0020, 1};
    segs[4]  = '{16'h0400, 1,  4'b0111, 16'h0020, 1};  // A glitch
    segs[5]  = '{16'h0000, 1,  4'b0111, 16'h0020, 1};
    segs[6]  = '{16'h0400, 5,  4'b0111, 16'h0400, 2};  // A real press
    segs[7]  = '{16'h0000, 3,  4'b1110, 16'h0400, 2};
    segs[8]  = '{16'h0000, 1,  4'b1101, 16'h0400, 2};
    segs[9]  = '{16'h0001, 4,  4'b1101, 16'h0001, 3};  // key 0
    segs[10] = '{16'h0000, 1,  4'b1101, 16'h0001, 3};  // release bounce
    segs[11] = '{16'h0001, 1,  4'b1101, 16'h0001, 3};
    segs[12] = '{16'h0000, 4,  4'b0111, 16'h0001, 3};
    segs[13] = '{16'h0000, 1,  4'b1110, 16'h0001, 3};
    segs[14] = '{16'h0082, 4,  4'b1110, 16'h0002, 4};  // 1 and 7 together
    segs[15] = '{16'h0080, 10, 4'b1110, 16'h0080, 5};  // 7 alone after wrap
    segs[16] = '{16'h0000, 3,  4'b1101, 16'h0080, 5};

    keys  = 16'h0000;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_col", 32'(kif.col), 32'(4'b1110));
    check("reset_new_key", 32'(kif.new_key), 32'(0));
    check("reset_value", 32'(kif.key_pressed_value), 32'(16'h0000));
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();

    for (int s = 0; s < 17; s++) begin
      for (int t = 0; t < segs[s].ticks; t++) tick_step(segs[s].keys);
      check("seg_col", 32'(kif.col), 32'(segs[s].exp_col));
      check("seg_value", 32'(kif.key_pressed_value), 32'(segs[s].exp_val));
      check("seg_pulses", 32'(obs_pulses), 32'(segs[s].exp_pulses));
      $display("[TB] seg %0d keys=%h ticks=%0d col=%b value=%h pulses=%0d",
               s, segs[s].keys, segs[s].ticks, kif.col, kif.key_pressed_value, obs_pulses);
    end

    // Reset while debouncing key 5 on column 1.
    tick_step(16'h0020);
    tick_step(16'h0020);
    #3 reset = 1'b0;
    #1;
    check("midreset_col", 32'(kif.col), 32'(4'b1110));
    check("midreset_new_key", 32'(kif.new_key), 32'(0));
    check("midreset_value", 32'(kif.key_pressed_value), 32'(16'h0000));
    keys = 16'h0000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    for (int t = 0; t < 6; t++) tick_step(16'h0000);
    check("post_reset_pulses", 32'(obs_pulses), 32'(m_pulses));
    $display("[TB] reset mid-debounce: col=%b value=%h pulses=%0d",
             kif.col, kif.key_pressed_value, obs_pulses);

    // Random key activity against the reference model.
    rk = 16'h0000;
    for (int s = 0; s < 40; s++) begin
      kind = $urandom_range(0, 3);
      dur  = $urandom_range(1, 6);
      case (kind)
        0: rk = 16'h0000;
        1: rk = 16'h0001 << $urandom_range(0, 15);
        2: rk = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
        default: rk = rk;
      endcase
      for (int t = 0; t < dur; t++) tick_step(rk);
      check("rand_pulses", 32'(obs_pulses), 32'(m_pulses));
      $display("[TB] rand %0d keys=%h ticks=%0d col=%b value=%h pulses=%0d",
               s, rk, dur, kif.col, kif.key_pressed_value, obs_pulses);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 hex keypad and debounces it.
- Emits a one-cycle new_key strobe plus a one-hot 16-bit key code for each debounced press.
- Sits upstream of store_keypresses and drives its new_key / key_pressed_value inputs directly.
- Guarantees exactly one strobe per physical press, with no strobes on release or bounce.

Parameters:
- SCAN_DIV, 4000: clk cycles per scan tick. Columns advance and rows are sampled only on ticks. Must be >= 2.
- DEBOUNCE_CNT, 20: consecutive stable ticks required to accept a press or a release. Must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- row  in  4  keypad rows, active-low (external pull-ups), asynchronous to clk
- col  out  4  keypad columns, active-low, at most one bit low at a time
- new_key  out  1  one-clk pulse on each accepted press
- key_pressed_value  out  16  one-hot code of the last accepted key; bit n set means hex digit n

Behaviour:
- Reset values (reset low, asynchronous): col=4'b1110, new_key=0, key_pressed_value=16'h0000, FSM=SCAN, tick counter=0, debounce counter=0, synchronizer flops=4'b1111.
- Synchronizer: row passes through 2 flops to give rs. All decisions use rs, sampled only on tick.
- Tick: counter runs 0..SCAN_DIV-1. tick is high for one clk when the counter reaches SCAN_DIV-1, then the counter wraps to 0.
- Key map, (row,col) -> digit:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E,0,F,D
- Row priority: if several rs bits are low, the lowest row index wins.
- FSM states: SCAN, PRESS_DB, HELD, RELEASE_DB.
- SCAN, on tick:
  - If rs==4'hF, rotate the active column 0->1->2->3->0 (col 1110->1101->1011->0111->1110).
  - Otherwise latch the candidate row, keep the column, set the debounce counter to 1, and go to PRESS_DB.
- PRESS_DB, on tick:
  - If the candidate row is still low, increment the counter.
  - When the counter reaches DEBOUNCE_CNT, load key_pressed_value, pulse new_key in the next clk, and go to HELD.
  - If the candidate row is high, return to SCAN with the column unchanged. No pulse.
- HELD: column stays frozen. On a tick with the candidate row high, set the counter to 1 and go to RELEASE_DB.
- RELEASE_DB, on tick:
  - Row high: increment the counter. At DEBOUNCE_CNT, go to SCAN and rotate to the next column.
  - Row low: return to HELD. No new pulse.
- Latency: new_key is asserted exactly 1 clk after the tick on which the debounce count hits DEBOUNCE_CNT. That is DEBOUNCE_CNT-1 ticks after the first-seen tick.
- new_key is high for exactly one clk per accepted press, never two consecutive clks.
- key_pressed_value holds its value between presses and across release.
- Multiple keys: in PRESS_DB/HELD/RELEASE_DB, other rows and columns are ignored. A second key held while the first is released is detected only after returning to SCAN, then it is debounced normally.
- Reset mid-operation returns to the reset values immediately. Any in-flight strobe is suppressed.
- When DEBOUNCE_CNT=1, a press is accepted on the first-seen tick.

Decomposition:
- Package keypad_pkg holds:
  - constants NUM_ROWS=4 and NUM_COLS=4
  - typedef key_state_t, the FSM enum
  - function key_onehot(row_idx, col_idx), which returns 16-bit one-hot from the key map
- One sub-module, scan_ticker: SCAN_DIV counter with tick output and the same clk/reset.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3):
- Reset release with rows all high -> col cycles 1110,1101,1011,0111,1110 every 4 clks; new_key never asserts; key_pressed_value stays 16'h0000.
- Key "5" (row1 low while col=1101), held 10 ticks then released -> col freezes at 1101; single new_key pulse; key_pressed_value=16'h0020; after 3 high ticks scanning resumes at col 1011.
- Bounce: key "A" (r0,c3) low for 1 tick, high 1 tick, low for 5 ticks -> no pulse on the first glitch; exactly one pulse with value 16'h0400.
- Release bounce: key "0" (r3,c1) held, then high 1 tick, low 1 tick, high 4 ticks -> exactly one pulse with value 16'h0001; no second pulse.
- Two keys on col0, rows 0 and 2 together -> value 16'h0002 ("1", lowest row); "7" is ignored until "1" is released. If "7" is still held afterwards, it is detected after the column wraps back to col0 and gives a second pulse with 16'h0080.
- Reset asserted during PRESS_DB -> col=1110 and new_key=0 immediately; no pulse after reset release while the row stays high.
